// File: rtl/approx_mult_err_monitor.sv
// Accuracy monitor for an approximate multiplier.
// Every accepted sample (a, b, r_approx) is compared against the exact
// product a*b in a two-stage pipeline. Over a run of num_samples samples it
// accumulates the saturating ED sum, the maximum ED and the number of
// inexact products. done pulses once the last sample has been folded in.
module approx_mult_err_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   r_approx,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_W-1:0]     sum_ed,
  output logic [2*WIDTH-1:0]   max_ed,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     sample_count
);

  localparam int PW    = 2 * WIDTH;
  // One extra bit over the wider of accumulator and ED so the add never wraps.
  localparam int SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] num_lat;

  logic             v1;
  logic             v2;
  logic [PW-1:0]    s1_exact;
  logic [PW-1:0]    s1_r;
  logic [PW-1:0]    ed;
  logic [PW-1:0]    ed_q;
  logic [SUM_W-1:0] sum_wide;

  logic accept;
  logic last_accept;
  logic start_ok;

  // Handshake and run-control decode from the registered state.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    in_ready    = 1'b0;
    busy        = 1'b0;
    start_ok    = 1'b0;
    accept      = 1'b0;
    last_accept = 1'b0;
    if (state == ST_RUN && sample_count < num_lat) in_ready = 1'b1;
    if (state == ST_RUN || state == ST_DRAIN)       busy     = 1'b1;
    if (start && (state == ST_IDLE || state == ST_DONE)) start_ok = 1'b1;
    accept      = in_valid && in_ready;
    last_accept = accept && (sample_count == num_lat - CNT_W'(1));
  end

  // Run FSM: owns state, the latched sample budget, sample_count and done.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state        <= ST_IDLE;
      num_lat      <= '0;
      sample_count <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            num_lat      <= num_samples;
            sample_count <= '0;
            if (num_samples == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            sample_count <= sample_count + CNT_W'(1);
            if (last_accept) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Stage 1 empty means the last sample is in stage 2 and retires on this edge.
          if (!v1) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pipeline valid flags: stage 1 fills on acceptance, stage 2 follows stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
    end
  end

  // Error distance between the registered exact and approximate products.
  always_comb begin
    ed = (s1_exact >= s1_r) ? (s1_exact - s1_r) : (s1_r - s1_exact);
  end

  // Datapath registers for stages 1 and 2; qualified by v1/v2.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers carry no reset; the valid flags decide whether they are used.
    if (accept) begin
      s1_exact <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      s1_r     <= r_approx;
    end
    if (v1) ed_q <= ed;
  end

  // Wide sum used to detect accumulator saturation.
  always_comb begin
    sum_wide = SUM_W'(sum_ed) + SUM_W'(ed_q);
  end

  // Result accumulators: cleared by an accepted start, updated by stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_ed    <= '0;
      max_ed    <= '0;
      err_count <= '0;
    end else if (start_ok) begin
      sum_ed    <= '0;
      max_ed    <= '0;
      err_count <= '0;
    end else if (v2) begin
      if (sum_wide > SUM_W'(ACC_MAX)) sum_ed <= ACC_MAX;
      else                            sum_ed <= sum_wide[ACC_W-1:0];
      if (ed_q > max_ed) max_ed <= ed_q;
      if (ed_q != '0)    err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed self-checking bench for approx_mult_err_monitor. A second
// instance with a 4-bit accumulator shares the stimulus to cover saturation.
module tb_approx_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] r_approx = '0;

  logic        in_ready, busy, done;
  logic [31:0] sum_ed;
  logic [15:0] max_ed, err_count, sample_count;

  logic        s_in_ready, s_busy, s_done;
  logic [3:0]  s_sum_ed;
  logic [15:0] s_max_ed, s_err_count, s_sample_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  approx_mult_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .r_approx(r_approx), .busy(busy), .done(done), .sum_ed(sum_ed),
    .max_ed(max_ed), .err_count(err_count), .sample_count(sample_count)
  );

  approx_mult_err_monitor #(.ACC_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
    .r_approx(r_approx), .busy(s_busy), .done(s_done), .sum_ed(s_sum_ed),
    .max_ed(s_max_ed), .err_count(s_err_count), .sample_count(s_sample_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] n);
    start       = 1'b1;
    num_samples = n;
    step();
    start = 1'b0;
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] rv);
    bit ok = 0;
    a = av; b = bv; r_approx = rv; in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1;
      step();
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Called right after the final accepting edge: done is high in the 3rd cycle.
  task automatic finish_run(input string tag);
    step();
    check({tag, "_done_early"}, {31'd0, done}, 32'd0);
    step();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
    step();
    check({tag, "_done_single"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic results(input string tag, input logic [31:0] s, input logic [15:0] m,
                         input logic [15:0] e, input logic [15:0] c);
    check({tag, "_sum_ed"}, sum_ed, s);
    check({tag, "_max_ed"}, {16'd0, max_ed}, {16'd0, m});
    check({tag, "_err_count"}, {16'd0, err_count}, {16'd0, e});
    check({tag, "_sample_count"}, {16'd0, sample_count}, {16'd0, c});
  endtask

  initial begin
    // Reset state
    #2;
    results("reset", 32'd0, 16'd0, 16'd0, 16'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Exact sample: ED 0
    go(16'd1);
    check("exact_busy", {31'd0, busy}, 32'd1);
    check("exact_in_ready", {31'd0, in_ready}, 32'd1);
    send(8'd3, 8'd5, 16'd15);
    check("exact_count_vis", {16'd0, sample_count}, 32'd1);
    check("exact_ready_drop", {31'd0, in_ready}, 32'd0);
    finish_run("exact");
    results("exact", 32'd0, 16'd0, 16'd0, 16'd1);

    // Under-estimates: EDs 1 and 16
    go(16'd2);
    send(8'd255, 8'd255, 16'hFE00);
    send(8'd16, 8'd16, 16'h00F0);
    finish_run("under");
    results("under", 32'd17, 16'd16, 16'd2, 16'd2);

    // Over-estimate with gaps: EDs 3, 0, 10; a start pulse mid-run is ignored
    go(16'd3);
    send(8'd2, 8'd2, 16'd7);
    step();
    start = 1'b1; num_samples = 16'd1;
    step();
    start = 1'b0;
    check("gap_ready_hold", {31'd0, in_ready}, 32'd1);
    check("gap_count_1", {16'd0, sample_count}, 32'd1);
    send(8'd10, 8'd10, 16'd100);
    step();
    step();
    check("gap_ready_hold2", {31'd0, in_ready}, 32'd1);
    send(8'd5, 8'd6, 16'd20);
    check("gap_ready_drop", {31'd0, in_ready}, 32'd0);
    check("gap_busy_drain", {31'd0, busy}, 32'd1);
    finish_run("gap");
    results("gap", 32'd13, 16'd10, 16'd2, 16'd3);

    // num_samples = 0: done the cycle after start, results cleared
    go(16'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_in_ready", {31'd0, in_ready}, 32'd0);
    check("zero_busy", {31'd0, busy}, 32'd0);
    results("zero", 32'd0, 16'd0, 16'd0, 16'd0);
    step();
    check("zero_done_single", {31'd0, done}, 32'd0);
    check("zero_in_ready2", {31'd0, in_ready}, 32'd0);

    // Saturation on the 4-bit accumulator instance: EDs 10 and 10
    go(16'd2);
    send(8'd3, 8'd4, 16'd2);
    send(8'd2, 8'd5, 16'd20);
    finish_run("sat");
    check("sat_sum_ed", {28'd0, s_sum_ed}, 32'd15);
    check("sat_max_ed", {16'd0, s_max_ed}, 32'd10);
    check("sat_err_count", {16'd0, s_err_count}, 32'd2);
    check("sat_wide_sum_ed", sum_ed, 32'd20);

    // Reset mid-run after 2 of 4 samples
    go(16'd4);
    send(8'd1, 8'd1, 16'd0);
    send(8'd2, 8'd2, 16'd0);
    step();
    step();
    results("pre_rst", 32'd5, 16'd4, 16'd2, 16'd2);
    #2;
    rst = 1'b1;
    #1;
    results("async_rst", 32'd0, 16'd0, 16'd0, 16'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Restart after reset: only new data counts; start during RUN ignored
    go(16'd2);
    start = 1'b1; num_samples = 16'd5;
    step();
    start = 1'b0;
    check("restart_busy", {31'd0, busy}, 32'd1);
    send(8'd7, 8'd7, 16'd49);
    send(8'd4, 8'd4, 16'd9);
    check("restart_ready_drop", {31'd0, in_ready}, 32'd0);
    finish_run("restart");
    results("restart", 32'd7, 16'd7, 16'd1, 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/approx_mult_err_monitor.md
Name: approx_mult_err_monitor

Overview:
- Downstream consumer of the 8x8 approximate multiplier outputs. Measures the multiplier's accuracy over a run of samples.
- Each sample is an operand pair A,B plus the approximate product R that the multiplier returned for it.
- Internally computes the exact product, then accumulates error distance (ED), maximum ED and the count of erroneous products over a programmed number of samples.
- Used by characterisation benches and the on-chip self-test of the approximate multiplier library; results are read after a done pulse.

Parameters:
- WIDTH, 8, operand width; the product is 2*WIDTH bits.
- CNT_W, 16, width of the sample counter and the error counter.
- ACC_W, 32, width of the ED sum accumulator (saturating).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse; begins a run; ignored unless in IDLE or DONE.
- num_samples  input  CNT_W  samples per run; sampled on start.
- in_valid  input  1  sample on a/b/r_approx is valid.
- in_ready  output  1  monitor accepts a sample this cycle.
- a  input  WIDTH  operand A given to the multiplier.
- b  input  WIDTH  operand B given to the multiplier.
- r_approx  input  2*WIDTH  approximate product R for (a,b).
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at end of run.
- sum_ed  output  ACC_W  sum of |a*b - r_approx|, saturating at all-ones.
- max_ed  output  2*WIDTH  largest single ED in the run.
- err_count  output  CNT_W  samples with ED != 0.
- sample_count  output  CNT_W  samples accepted so far in the run.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs go to 0: in_ready, busy, done, sum_ed, max_ed, err_count, sample_count.
  - Both pipeline valid flags clear.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE with start=1:
  - Clear sum_ed, max_ed, err_count and sample_count.
  - Latch num_samples.
  - If the latched value is 0, go to DONE and pulse done on the next cycle; otherwise go to RUN.
- Handshake:
  - in_ready = 1 only in RUN while sample_count < latched num_samples.
  - A sample is accepted on a clock edge where in_valid && in_ready.
  - in_valid may drop at any time; gaps are allowed and nothing is lost.
- Pipeline, two stages:
  - S1: register exact = a*b (full 2*WIDTH, unsigned) and r_approx, and set v1.
  - S2: ED = exact >= r ? exact - r : r - exact. Then:
    - sum_ed += ED, saturating at all-ones.
    - max_ed = max(max_ed, ED).
    - err_count += (ED != 0).
    - err_count never exceeds sample_count, so it cannot wrap.
- sample_count increments on each acceptance. It is visible one cycle after the accepting edge.
- RUN -> DRAIN on the edge that accepts the final sample (sample_count reaches num_samples).
- DRAIN: wait until both pipeline stages are empty, then go to DONE.
  - The final sample updates the accumulators 2 edges after it is accepted.
  - done pulses in the cycle after that update, i.e. it is high during the 3rd cycle after the final accepting edge.
- DONE: results hold stable until the next start or reset; done is high for one cycle only.
- start during RUN or DRAIN is ignored; num_samples changes mid-run are ignored.
- rst mid-run: all state is discarded immediately and results read 0.

Test Plan:
- Exact sample: start with num_samples=1, then a=3, b=5, r_approx=15 -> sum_ed=0, max_ed=0, err_count=0, sample_count=1; done pulses 3 cycles after acceptance.
- Under-estimate: 2 samples, (255,255,r=0xFE00) and (16,16,r=0x00F0) -> EDs 1 and 16; sum_ed=17, max_ed=16, err_count=2.
- Over-estimate plus gaps: 3 samples with in_valid low 2 cycles between each, incl. (2,2,r=7) -> ED 3; the run takes exactly 3 acceptances and in_ready drops after the 3rd.
- num_samples=0: start -> done one cycle later; all results 0; in_ready stays 0.
- Saturation: set ACC_W=4, feed 2 samples with ED=10 each -> sum_ed=15 (saturated), max_ed=10, err_count=2.
- Reset and restart: assert rst after 2 of 4 samples -> all outputs 0 asynchronously. A new start ignores the earlier data, and a start pulse during RUN has no effect.
